// File: rtl/game_pkg.sv
// Key codes and selection-FSM encoding shared by the cursor/select controller and its buffer.
package game_pkg;

  typedef logic [2:0] key_code_t;

  localparam key_code_t KEY_UP     = 3'd0;
  localparam key_code_t KEY_DOWN   = 3'd1;
  localparam key_code_t KEY_LEFT   = 3'd2;
  localparam key_code_t KEY_RIGHT  = 3'd3;
  localparam key_code_t KEY_SELECT = 3'd4;
  localparam key_code_t KEY_CANCEL = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSel1 = 2'd1,
    StReq  = 2'd2
  } sel_state_e;

  // Codes above CANCEL are reserved and never reach the FSM or the buffer.
  function automatic logic is_valid_key(key_code_t code);
    return code <= KEY_CANCEL;
  endfunction

endpackage

// File: rtl/key_event_buf.sv
// One-entry key event buffer; holds a single code while a swap request is outstanding.
module key_event_buf
  import game_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  key_code_t din,
  input  logic      pop,
  output logic      push_ok,
  output logic      full,
  output key_code_t dout
);

  logic      full_q;
  key_code_t code_q;

  // A pop in the same cycle frees the slot for the incoming event.
  assign push_ok = !full_q || pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      code_q <= '0;
    end else if (push && push_ok) begin
      full_q <= 1'b1;
      code_q <= din;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign dout = code_q;

endmodule

// File: rtl/cursor_select_ctrl.sv
// Turns key events into cursor motion and a two-cell swap request; buffers one event
// while the request is outstanding.
module cursor_select_ctrl
  import game_pkg::*;
#(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 8,
  parameter bit          WRAP = 1'b1,
  localparam int unsigned XW  = $clog2(COLS),
  localparam int unsigned YW  = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  key_code_t     key_code,
  input  logic          key_valid,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          sel_active,
  output logic [XW-1:0] sel_a_x,
  output logic [YW-1:0] sel_a_y,
  output logic [XW-1:0] sel_b_x,
  output logic [YW-1:0] sel_b_y,
  output logic          swap_req,
  input  logic          swap_ack,
  output logic          key_drop
);

  localparam logic [XW-1:0] XMax = XW'(COLS - 1);
  localparam logic [YW-1:0] YMax = YW'(ROWS - 1);

  sel_state_e    state_q, state_d;
  logic [XW-1:0] cur_x_q, cur_x_d, sel_a_x_q, sel_a_x_d, sel_b_x_q, sel_b_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d, sel_a_y_q, sel_a_y_d, sel_b_y_q, sel_b_y_d;
  logic          drop_q;

  logic      key_ok, in_req, buf_full, buf_pop, buf_push, buf_push_ok, ev_valid;
  key_code_t buf_dout, ev_code;
  logic      on_a, adj_a;
  int        dx, dy;

  assign key_ok = key_valid && is_valid_key(key_code);
  assign in_req = (state_q == StReq);
  // Once an event is buffered, newer events queue behind it so key order is preserved.
  assign buf_pop  = !in_req && buf_full;
  assign buf_push = key_ok && (in_req || buf_full);
  assign ev_valid = buf_pop || (key_ok && !buf_push);
  assign ev_code  = buf_pop ? buf_dout : key_code;

  key_event_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .push    (buf_push),
    .din     (key_code),
    .pop     (buf_pop),
    .push_ok (buf_push_ok),
    .full    (buf_full),
    .dout    (buf_dout)
  );

  // Board adjacency is plain 4-neighbour distance; wrap never makes edge cells adjacent.
  always_comb begin
    dx    = int'(cur_x_q) - int'(sel_a_x_q);
    dy    = int'(cur_y_q) - int'(sel_a_y_q);
    on_a  = (dx == 0) && (dy == 0);
    adj_a = ((dx == 1 || dx == -1) && dy == 0) || ((dy == 1 || dy == -1) && dx == 0);
  end

  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    sel_a_x_d = sel_a_x_q;
    sel_a_y_d = sel_a_y_q;
    sel_b_x_d = sel_b_x_q;
    sel_b_y_d = sel_b_y_q;
    if (ev_valid) begin
      case (ev_code)
        KEY_UP:    cur_y_d = (cur_y_q == '0) ? (WRAP ? YMax : '0) : cur_y_q - YW'(1);
        KEY_DOWN:  cur_y_d = (cur_y_q == YMax) ? (WRAP ? '0 : YMax) : cur_y_q + YW'(1);
        KEY_LEFT:  cur_x_d = (cur_x_q == '0) ? (WRAP ? XMax : '0) : cur_x_q - XW'(1);
        KEY_RIGHT: cur_x_d = (cur_x_q == XMax) ? (WRAP ? '0 : XMax) : cur_x_q + XW'(1);
        KEY_SELECT: begin
          if (state_q == StIdle) begin
            sel_a_x_d = cur_x_q;
            sel_a_y_d = cur_y_q;
            state_d   = StSel1;
          end else if (on_a) begin
            state_d = StIdle;
          end else if (adj_a) begin
            sel_b_x_d = cur_x_q;
            sel_b_y_d = cur_y_q;
            state_d   = StReq;
          end else begin
            sel_a_x_d = cur_x_q;
            sel_a_y_d = cur_y_q;
          end
        end
        KEY_CANCEL: if (state_q == StSel1) state_d = StIdle;
        default: ;
      endcase
    end
    if (in_req && swap_ack) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      sel_a_x_q <= '0;
      sel_a_y_q <= '0;
      sel_b_x_q <= '0;
      sel_b_y_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      sel_a_x_q <= sel_a_x_d;
      sel_a_y_q <= sel_a_y_d;
      sel_b_x_q <= sel_b_x_d;
      sel_b_y_q <= sel_b_y_d;
      drop_q    <= buf_push && !buf_push_ok;
    end
  end

  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign sel_a_x    = sel_a_x_q;
  assign sel_a_y    = sel_a_y_q;
  assign sel_b_x    = sel_b_x_q;
  assign sel_b_y    = sel_b_y_q;
  assign sel_active = (state_q != StIdle);
  assign swap_req   = in_req;
  assign key_drop   = drop_q;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Drives a wrapping and a saturating instance with shared stimulus; checks both against a model.
module tb_cursor_select_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam logic [2:0] K_UP = 3'd0, K_DOWN = 3'd1, K_LEFT = 3'd2, K_RIGHT = 3'd3;
  localparam logic [2:0] K_SEL = 3'd4, K_CAN = 3'd5;

  logic       clk, reset, key_valid, swap_ack;
  logic [2:0] key_code;
  logic [2:0] cx0, cy0, ax0, ay0, bx0, by0, cx1, cy1, ax1, ay1, bx1, by1;
  logic       act0, req0, drop0, act1, req1, drop1;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // Model state per instance: index 0 wraps, index 1 saturates. mode 0 idle, 1 one cell, 2 req.
  int m_cx[2], m_cy[2], m_ax[2], m_ay[2], m_bx[2], m_by[2], m_mode[2];
  int m_pend_n[2], m_pend_c[2];
  bit m_drop[2];

  cursor_select_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .cur_x(cx0), .cur_y(cy0), .sel_active(act0), .sel_a_x(ax0), .sel_a_y(ay0),
    .sel_b_x(bx0), .sel_b_y(by0), .swap_req(req0), .swap_ack(swap_ack), .key_drop(drop0)
  );

  cursor_select_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .cur_x(cx1), .cur_y(cy1), .sel_active(act1), .sel_a_x(ax1), .sel_a_y(ay1),
    .sel_b_x(bx1), .sel_b_y(by1), .swap_req(req1), .swap_ack(swap_ack), .key_drop(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input int i, input int ev, input bit wrap);
    int dx, dy;
    case (ev)
      0: m_cy[i] = wrap ? (m_cy[i] + ROWS - 1) % ROWS : (m_cy[i] > 0 ? m_cy[i] - 1 : 0);
      1: m_cy[i] = wrap ? (m_cy[i] + 1) % ROWS : (m_cy[i] < ROWS - 1 ? m_cy[i] + 1 : ROWS - 1);
      2: m_cx[i] = wrap ? (m_cx[i] + COLS - 1) % COLS : (m_cx[i] > 0 ? m_cx[i] - 1 : 0);
      3: m_cx[i] = wrap ? (m_cx[i] + 1) % COLS : (m_cx[i] < COLS - 1 ? m_cx[i] + 1 : COLS - 1);
      4: begin
        dx = m_cx[i] - m_ax[i];
        dy = m_cy[i] - m_ay[i];
        if (m_mode[i] == 0) begin
          m_ax[i] = m_cx[i]; m_ay[i] = m_cy[i]; m_mode[i] = 1;
        end else if (dx == 0 && dy == 0) begin
          m_mode[i] = 0;
        end else if ((dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy) == 1) begin
          m_bx[i] = m_cx[i]; m_by[i] = m_cy[i]; m_mode[i] = 2;
        end else begin
          m_ax[i] = m_cx[i]; m_ay[i] = m_cy[i];
        end
      end
      5: if (m_mode[i] == 1) m_mode[i] = 0;
      default: ;
    endcase
  endtask

  task automatic model_step(input int i);
    bit was_req, have;
    int ev;
    if (reset) begin
      m_cx[i] = 0; m_cy[i] = 0; m_ax[i] = 0; m_ay[i] = 0; m_bx[i] = 0; m_by[i] = 0;
      m_mode[i] = 0; m_pend_n[i] = 0; m_drop[i] = 1'b0;
      return;
    end
    was_req   = (m_mode[i] == 2);
    m_drop[i] = 1'b0;
    have      = 1'b0;
    ev        = 0;
    if (!was_req && m_pend_n[i] > 0) begin
      ev = m_pend_c[i]; m_pend_n[i] = 0; have = 1'b1;
    end
    if (key_valid && int'(key_code) <= 5) begin
      if (was_req || have) begin
        if (m_pend_n[i] == 0) begin
          m_pend_c[i] = int'(key_code); m_pend_n[i] = 1;
        end else begin
          m_drop[i] = 1'b1;
        end
      end else begin
        ev = int'(key_code); have = 1'b1;
      end
    end
    if (was_req) begin
      if (swap_ack) m_mode[i] = 0;
    end else if (have) begin
      apply(i, ev, i == 0);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic cmp(input int i, input logic [2:0] cx, cy, ax, ay, bx, by,
                     input logic act, req, drop);
    check($sformatf("u%0d cur_x", i), 32'(cx), m_cx[i]);
    check($sformatf("u%0d cur_y", i), 32'(cy), m_cy[i]);
    check($sformatf("u%0d sel_a_x", i), 32'(ax), m_ax[i]);
    check($sformatf("u%0d sel_a_y", i), 32'(ay), m_ay[i]);
    check($sformatf("u%0d sel_b_x", i), 32'(bx), m_bx[i]);
    check($sformatf("u%0d sel_b_y", i), 32'(by), m_by[i]);
    check($sformatf("u%0d sel_active", i), 32'(act), int'(m_mode[i] != 0));
    check($sformatf("u%0d swap_req", i), 32'(req), int'(m_mode[i] == 2));
    check($sformatf("u%0d key_drop", i), 32'(drop), int'(m_drop[i]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, cx0, cy0, ax0, ay0, bx0, by0, act0, req0, drop0);
      cmp(1, cx1, cy1, ax1, ay1, bx1, by1, act1, req1, drop1);
    end
  end

  task automatic drive(input logic r, input logic kv, input logic [2:0] kc, input logic ack);
    @(negedge clk);
    reset     = r;
    key_valid = kv;
    key_code  = kc;
    swap_ack  = ack;
  endtask

  task automatic key(input logic [2:0] k);
    drive(1'b0, 1'b1, k, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rst();
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    idle(1);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 3'd0; swap_ack = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    rst();
    started = 1'b1;
    check("reset cur_x", 32'(cx0), 0);
    check("reset swap_req", 32'(req0), 0);

    // Cursor moves, one-cycle latency
    key(K_RIGHT); idle(1);
    check("latency cur_x", 32'(cx0), 1);
    key(K_RIGHT); key(K_RIGHT); key(K_DOWN); key(K_DOWN); idle(1);
    check("moves cur_x", 32'(cx0), 3);
    check("moves cur_y", 32'(cy0), 2);
    check("moves sat cur_x", 32'(cx1), 3);

    // Edges: wrap vs saturate
    rst();
    key(K_LEFT); idle(1);
    check("wrap left", 32'(cx0), 7);
    check("sat left", 32'(cx1), 0);
    key(K_UP); idle(1);
    check("wrap up", 32'(cy0), 7);
    check("sat up", 32'(cy1), 0);

    // Adjacent swap request, hold, ack
    rst();
    key(K_RIGHT); key(K_RIGHT); key(K_DOWN); key(K_DOWN);
    key(K_SEL); key(K_RIGHT); key(K_SEL); idle(1);
    check("swap req", 32'(req0), 1);
    check("swap sel_a_x", 32'(ax0), 2);
    check("swap sel_a_y", 32'(ay0), 2);
    check("swap sel_b_x", 32'(bx0), 3);
    check("swap sel_b_y", 32'(by0), 2);
    idle(10);
    check("swap held", 32'(req0), 1);
    drive(1'b0, 1'b0, 3'd0, 1'b1); idle(1);
    check("ack drops req", 32'(req0), 0);
    check("ack idle", 32'(act0), 0);

    // Non-adjacent reselect, deselect, cancel in idle
    rst();
    key(K_RIGHT); key(K_DOWN); key(K_SEL);
    key(K_RIGHT); key(K_RIGHT); key(K_RIGHT); key(K_DOWN); key(K_DOWN); key(K_DOWN);
    key(K_SEL); idle(1);
    check("reselect active", 32'(act0), 1);
    check("reselect no req", 32'(req0), 0);
    check("reselect sel_a_x", 32'(ax0), 4);
    check("reselect sel_a_y", 32'(ay0), 4);
    key(K_SEL); idle(1);
    check("deselect", 32'(act0), 0);
    key(K_CAN); idle(1);
    check("cancel idle x", 32'(cx0), 4);
    check("cancel idle active", 32'(act0), 0);

    // Buffering and drop during a request
    rst();
    key(K_SEL); key(K_RIGHT); key(K_SEL);
    key(K_DOWN); key(K_LEFT); idle(1);
    check("drop pulse", 32'(drop0), 1);
    idle(1);
    check("drop one cycle", 32'(drop0), 0);
    drive(1'b0, 1'b0, 3'd0, 1'b1); idle(1);
    check("post-ack y", 32'(cy0), 0);
    idle(1);
    check("buffered down y", 32'(cy0), 1);
    check("buffered down x", 32'(cx0), 1);

    // Reset during request with a full buffer
    rst();
    key(K_SEL); key(K_RIGHT); key(K_SEL); key(K_DOWN); idle(1);
    check("pre-reset req", 32'(req0), 1);
    rst();
    check("reset req", 32'(req0), 0);
    check("reset cur_x", 32'(cx0), 0);
    check("reset active", 32'(act0), 0);
    idle(1);
    check("reset buf empty y", 32'(cy0), 0);
    key(K_RIGHT); idle(1);
    check("after reset x", 32'(cx0), 1);
    key(3'd6); idle(1);
    check("reserved x", 32'(cx0), 1);
    check("reserved drop", 32'(drop0), 0);

    // Random traffic
    repeat (3000) begin
      logic       r, kv, ack;
      logic [2:0] kc;
      r   = ($urandom_range(0, 199) == 0);
      kv  = ($urandom_range(0, 1) == 1);
      kc  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) kc = K_SEL;
      ack = ($urandom_range(0, 5) == 0);
      drive(r, kv, kc, ack);
    end
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
